// File: rtl/seg7_scan_reader.sv
// ============================================================================
// Module   : seg7_scan_reader
// Purpose  : Rebuilds the 16-bit value shown on a multiplexed 4-digit 7-segment bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_reader #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic        dp_in,
  input  logic [3:0]  dig_en,
  output logic [15:0] value,
  output logic        dp_out,
  output logic        valid,
  output logic        err,
  output logic [3:0]  err_digit,
  output logic        timeout
);

  localparam int c_SCW = $clog2(STABLE_CYCLES + 1);
  localparam int c_TCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_SCW-1:0] c_STABLE = c_SCW'(STABLE_CYCLES);
  localparam logic [c_TCW-1:0] c_TLAST  = c_TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_lat_en;
  logic [6:0]         r_lat_seg;
  logic               r_lat_dp;
  logic [c_SCW-1:0]   r_cnt;
  logic [c_TCW-1:0]   r_tcnt;
  logic [3:0]         r_mask;
  logic [15:0]        r_sh_val;
  logic [3:0]         r_sh_err;
  logic               r_sh_dp;

  logic [6:0]         w_seg;
  logic               w_dp;
  logic               w_onehot;
  logic               w_same;
  logic               w_load;
  logic               w_cnt_inc;
  logic               w_cap;
  logic [3:0]         w_cap_bit;
  logic [4:0]         w_dec;
  logic               w_done;
  logic               w_expire;
  logic [3:0]         w_base;

  // Returns {undecodable, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] f_decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign w_seg    = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
  assign w_dp     = SEG_ACTIVE_LOW ? ~dp_in  : dp_in;
  assign w_onehot = (dig_en != 4'd0) && ((dig_en & (dig_en - 4'd1)) == 4'd0);
  assign w_same   = (dig_en == r_lat_en) && (w_seg == r_lat_seg) && (w_dp == r_lat_dp);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_load      = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // The latched sample has been seen STABLE_CYCLES times; commit it.
        w_cap = (r_cnt == c_STABLE);
        if (w_same) begin
          if (w_cap) w_state_nxt = S_HOLD;
          else       w_cnt_inc   = 1'b1;
        end else if (w_onehot) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!w_same) begin
          if (w_onehot) begin
            w_load      = 1'b1;
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_dec     = f_decode(r_lat_seg);
  assign w_cap_bit = w_cap ? r_lat_en : 4'd0;
  assign w_done    = (r_mask == 4'hF);
  assign w_expire  = !w_done && (r_mask != 4'd0) && (r_tcnt == c_TLAST);
  // Mask as seen by this cycle's capture: completion/timeout start a fresh frame.
  assign w_base    = (w_done || w_expire) ? 4'd0 : r_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lat_en  <= 4'd0;
      r_lat_seg <= 7'd0;
      r_lat_dp  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_lat_en  <= dig_en;
        r_lat_seg <= w_seg;
        r_lat_dp  <= w_dp;
        r_cnt     <= c_SCW'(1);
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + c_SCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask    <= 4'd0;
      r_tcnt    <= '0;
      r_sh_val  <= 16'd0;
      r_sh_err  <= 4'd0;
      r_sh_dp   <= 1'b0;
      value     <= 16'd0;
      dp_out    <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      err_digit <= 4'd0;
      timeout   <= 1'b0;
    end else begin
      r_mask  <= w_base | w_cap_bit;
      valid   <= w_done;
      timeout <= w_expire;

      if (w_cap && (w_base == 4'd0)) r_tcnt <= '0;
      else if (w_base != 4'd0)       r_tcnt <= r_tcnt + c_TCW'(1);

      if (w_expire) begin
        r_sh_val <= 16'd0;
        r_sh_err <= 4'd0;
        r_sh_dp  <= 1'b0;
      end
      for (int d = 0; d < 4; d++) begin
        if (w_cap_bit[d]) begin
          r_sh_val[d*4 +: 4] <= w_dec[3:0];
          r_sh_err[d]        <= w_dec[4];
        end
      end
      if (w_cap_bit[3]) r_sh_dp <= r_lat_dp;

      if (w_done) begin
        value     <= r_sh_val;
        dp_out    <= r_sh_dp;
        err_digit <= r_sh_err;
        err       <= |r_sh_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
// ============================================================================
// Module   : tb_seg7_scan_reader
// Purpose  : Scoreboard bench driving one logical stimulus into active-high and active-low readers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_reader;

  localparam int c_TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dig_en;
  logic [6:0]  seg_h;
  logic        dp_h;
  logic [6:0]  w_seg_l;
  logic        w_dp_l;

  logic [15:0] ah_value, al_value;
  logic        ah_dp, al_dp, ah_valid, al_valid, ah_err, al_err, ah_to, al_to;
  logic [3:0]  ah_ed, al_ed;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          to_ah   = 0;
  int          to_al   = 0;
  logic [20:0] sb_q[$];
  logic [20:0] r_exp;
  logic [6:0]  c_enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  assign w_seg_l = ~seg_h;
  assign w_dp_l  = ~dp_h;

  always #5 clk = ~clk;

  seg7_scan_reader #(.SEG_ACTIVE_LOW(1'b0), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(c_TO)) u_dut_ah (
    .clk(clk), .reset(reset), .seg_in(seg_h), .dp_in(dp_h), .dig_en(dig_en),
    .value(ah_value), .dp_out(ah_dp), .valid(ah_valid), .err(ah_err),
    .err_digit(ah_ed), .timeout(ah_to)
  );

  seg7_scan_reader #(.SEG_ACTIVE_LOW(1'b1), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(c_TO)) u_dut_al (
    .clk(clk), .reset(reset), .seg_in(w_seg_l), .dp_in(w_dp_l), .dig_en(dig_en),
    .value(al_value), .dp_out(al_dp), .valid(al_valid), .err(al_err),
    .err_digit(al_ed), .timeout(al_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ah_to) to_ah++;
    if (al_to) to_al++;
    if (ah_valid || al_valid) begin
      check("valid_pair", 32'(al_valid), 32'(ah_valid));
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        r_exp = sb_q.pop_front();
        check("value_ah", 32'(ah_value), 32'(r_exp[15:0]));
        check("value_al", 32'(al_value), 32'(r_exp[15:0]));
        check("dp_ah", 32'(ah_dp), 32'(r_exp[20]));
        check("dp_al", 32'(al_dp), 32'(r_exp[20]));
        check("err_digit_ah", 32'(ah_ed), 32'(r_exp[19:16]));
        check("err_digit_al", 32'(al_ed), 32'(r_exp[19:16]));
        check("err_ah", 32'(ah_err), 32'(|r_exp[19:16]));
        check("err_al", 32'(al_err), 32'(|r_exp[19:16]));
      end
    end
  end

  task automatic hold(input logic [3:0] en, input logic [6:0] p, input logic dp, input int n);
    dig_en = en;
    seg_h  = p;
    dp_h   = dp;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] v, input logic [3:0] emask, input logic [3:0] dpm);
    logic [15:0] ev;
    ev = v;
    for (int d = 0; d < 4; d++)
      if (emask[d]) ev[d*4 +: 4] = 4'h0;
    sb_q.push_back({dpm[3], emask, ev});
    for (int d = 0; d < 4; d++)
      hold(4'(1 << d), emask[d] ? 7'h00 : c_enc[v[d*4 +: 4]], dpm[d], 8);
    hold(4'd0, 7'd0, 1'b0, 10);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_value"}, 32'(ah_value), 32'd0);
    check({tag, "_value_al"}, 32'(al_value), 32'd0);
    check({tag, "_dp"}, 32'(ah_dp | al_dp), 32'd0);
    check({tag, "_valid"}, 32'(ah_valid | al_valid), 32'd0);
    check({tag, "_err"}, 32'(ah_err | al_err), 32'd0);
    check({tag, "_err_digit"}, 32'(ah_ed | al_ed), 32'd0);
    check({tag, "_timeout"}, 32'(ah_to | al_to), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    dig_en = 4'd0;
    seg_h  = 7'd0;
    dp_h   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    reset = 1'b0;
    hold(4'd0, 7'd0, 1'b0, 3);

    frame(16'h0136, 4'b0000, 4'b0000);
    frame(16'h3210, 4'b0000, 4'b1000);
    frame(16'hABCD, 4'b0000, 4'b0001);
    frame(16'hEF98, 4'b0000, 4'b0000);
    frame(16'h5A7C, 4'b0100, 4'b0000);

    // 2-cycle glitch on digit 1 must not be captured
    sb_q.push_back({1'b0, 4'b0000, 16'h4231});
    hold(4'b0001, c_enc[1], 1'b0, 8);
    hold(4'b0010, c_enc[2], 1'b0, 2);
    hold(4'b0010, c_enc[3], 1'b0, 8);
    hold(4'b0100, c_enc[2], 1'b0, 8);
    hold(4'b1000, c_enc[4], 1'b0, 8);
    hold(4'd0, 7'd0, 1'b0, 10);

    // digit 0 captured twice, latest wins
    sb_q.push_back({1'b0, 4'b0000, 16'h9807});
    hold(4'b0001, c_enc[5], 1'b0, 8);
    hold(4'd0, 7'd0, 1'b0, 2);
    hold(4'b0001, c_enc[7], 1'b0, 8);
    hold(4'b0010, c_enc[0], 1'b0, 8);
    hold(4'b0100, c_enc[8], 1'b0, 8);
    hold(4'b1000, c_enc[9], 1'b0, 8);
    hold(4'd0, 7'd0, 1'b0, 10);

    // partial frame times out
    hold(4'b0001, c_enc[1], 1'b0, 8);
    hold(4'b0010, c_enc[2], 1'b0, 8);
    hold(4'd0, 7'd0, 1'b0, c_TO + 16);
    check("timeout_cnt1_ah", 32'(to_ah), 32'd1);
    check("timeout_cnt1_al", 32'(to_al), 32'd1);
    check("value_kept", 32'(ah_value), 32'h9807);
    frame(16'hFEDC, 4'b0000, 4'b0000);

    // non-one-hot strobe never captured: digits 2,3 alone must time out
    hold(4'b0100, c_enc[3], 1'b0, 8);
    hold(4'b1000, c_enc[4], 1'b0, 8);
    hold(4'b0011, c_enc[5], 1'b0, 8);
    hold(4'd0, 7'd0, 1'b0, c_TO + 16);
    check("timeout_cnt2_ah", 32'(to_ah), 32'd2);
    check("timeout_cnt2_al", 32'(to_al), 32'd2);

    // reset between digits 2 and 3
    hold(4'b0011, c_enc[6], 1'b0, 8);
    hold(4'b0001, c_enc[1], 1'b0, 8);
    hold(4'b0010, c_enc[2], 1'b0, 8);
    hold(4'b0100, c_enc[3], 1'b0, 8);
    reset = 1'b1;
    hold(4'b1000, c_enc[0], 1'b0, 2);
    reset = 1'b0;
    check_reset_outputs("rst1");
    hold(4'b1000, c_enc[9], 1'b0, 8);
    hold(4'd0, 7'd0, 1'b0, c_TO + 16);
    check("timeout_cnt3_ah", 32'(to_ah), 32'd3);
    check("timeout_cnt3_al", 32'(to_al), 32'd3);
    check("value_after_rst", 32'(ah_value), 32'd0);

    hold(4'd0, 7'd0, 1'b0, 5);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
